// File: rtl/eggtimer_ctrl_pkg.sv
// Shared encodings for the egg timer: mode states and BCD digit limits.
package eggtimer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX = 4'd9;

  // Index of each button inside the packed press-event vector.
  localparam int unsigned BTN_SEC   = 0;
  localparam int unsigned BTN_MIN   = 1;
  localparam int unsigned BTN_START = 2;
  localparam int unsigned BTN_CLEAR = 3;

endpackage

// File: rtl/eggtimer_ctrl_bcd_digit.sv
// One BCD digit with wrap-around increment/decrement; carries are chained outside.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count,
  output logic       at_max,
  output logic       at_zero
);

  assign at_max  = (count == MAX);
  assign at_zero = (count == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (inc) begin
      count <= at_max ? 4'd0 : count + 4'd1;
    end else if (dec) begin
      count <= at_zero ? MAX : count - 4'd1;
    end
  end

endmodule

// File: rtl/eggtimer_ctrl.sv
// Egg timer sequencer: button edge detection, MM:SS BCD count and SET/RUN/PAUSE/ALARM mode FSM.
//
//   state    | meaning
//   ST_SET   | time editable with sec/min buttons; start leaves if time is non-zero
//   ST_RUN   | counting down once per tick; reaching 00:00 raises the alarm
//   ST_PAUSE | time frozen; start resumes
//   ST_ALARM | time at 00:00; any press or ALARM_TICKS ticks returns to SET
module eggtimer_ctrl
  import eggtimer_ctrl_pkg::*;
#(
  parameter int unsigned ALARM_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       btn_sec,
  input  logic       btn_min,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm,
  output logic [1:0] state
);

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  state_t     state_q;
  logic [7:0] alarm_cnt;
  logic [3:0] btn_lvl;
  logic [3:0] btn_prev;
  logic [3:0] ev;

  logic ev_sec, ev_min, ev_start, ev_clear;
  logic time_zero, time_one;
  logic do_sec, do_min, do_dec;

  logic so_max, so_zero, st_max, st_zero, mo_max, mo_zero, mt_max, mt_zero;
  logic so_inc, st_inc, mo_inc, mt_inc;
  logic so_dec, st_dec, mo_dec, mt_dec;

  assign btn_lvl = {btn_clear, btn_start, btn_min, btn_sec};

  // Previous levels reset high so a button held through reset is not seen as a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev <= 4'hF;
    end else begin
      btn_prev <= btn_lvl;
    end
  end

  assign ev       = btn_lvl & ~btn_prev;
  assign ev_sec   = ev[BTN_SEC];
  assign ev_min   = ev[BTN_MIN];
  assign ev_start = ev[BTN_START];
  assign ev_clear = ev[BTN_CLEAR];

  assign time_zero = so_zero & st_zero & mo_zero & mt_zero;
  assign time_one  = (sec_ones == 4'd1) & st_zero & mo_zero & mt_zero;

  always_comb begin
    do_sec = 1'b0;
    do_min = 1'b0;
    do_dec = 1'b0;
    if (!ev_clear) begin
      case (state_q)
        ST_SET: begin
          // A start that actually leaves SET wins over edits in the same cycle.
          if (!(ev_start && !time_zero)) begin
            do_sec = ev_sec;
            do_min = ev_min;
          end
        end
        ST_RUN:  do_dec = tick_1hz;
        default: ;
      endcase
    end
  end

  // Seconds wrap 59 -> 00 without touching minutes; minutes wrap 99 -> 00.
  assign so_inc = do_sec;
  assign st_inc = do_sec & so_max;
  assign mo_inc = do_min;
  assign mt_inc = do_min & mo_max;

  assign so_dec = do_dec;
  assign st_dec = do_dec & so_zero;
  assign mo_dec = st_dec & st_zero;
  assign mt_dec = mo_dec & mo_zero;

  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ev_clear),
    .inc     (so_inc),
    .dec     (so_dec),
    .count   (sec_ones),
    .at_max  (so_max),
    .at_zero (so_zero)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ev_clear),
    .inc     (st_inc),
    .dec     (st_dec),
    .count   (sec_tens),
    .at_max  (st_max),
    .at_zero (st_zero)
  );

  bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ev_clear),
    .inc     (mo_inc),
    .dec     (mo_dec),
    .count   (min_ones),
    .at_max  (mo_max),
    .at_zero (mo_zero)
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ev_clear),
    .inc     (mt_inc),
    .dec     (mt_dec),
    .count   (min_tens),
    .at_max  (mt_max),
    .at_zero (mt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_SET;
      running   <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= 8'd0;
    end else if (ev_clear) begin
      state_q   <= ST_SET;
      running   <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= 8'd0;
    end else begin
      case (state_q)
        ST_SET: begin
          if (ev_start && !time_zero) begin
            state_q <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          // The final decrement to 00:00 takes precedence over a same-cycle pause.
          if (tick_1hz && time_one) begin
            state_q <= ST_ALARM;
            running <= 1'b0;
            alarm   <= 1'b1;
          end else if (ev_start) begin
            state_q <= ST_PAUSE;
            running <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (ev_start) begin
            state_q <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_ALARM: begin
          if (ev_sec || ev_min || ev_start) begin
            state_q   <= ST_SET;
            alarm     <= 1'b0;
            alarm_cnt <= 8'd0;
          end else if (tick_1hz) begin
            if (alarm_cnt == ALARM_LAST) begin
              state_q   <= ST_SET;
              alarm     <= 1'b0;
              alarm_cnt <= 8'd0;
            end else begin
              alarm_cnt <= alarm_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_q <= ST_SET;
          running <= 1'b0;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_eggtimer_ctrl.sv
// Self-checking bench for eggtimer_ctrl: directed scenarios then random buttons/ticks against a seconds-level model.
module tb_eggtimer_ctrl;

  localparam int AT = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_sec = 1'b0, btn_min = 1'b0, btn_start = 1'b0, btn_clear = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, alarm;
  logic [1:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: minutes/seconds as plain integers, mode as 0..3.
  int m_mm, m_ss, m_st, m_ac;
  bit p_sec, p_min, p_start, p_clear;

  eggtimer_ctrl #(.ALARM_TICKS(AT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_1hz  (tick_1hz),
    .btn_sec   (btn_sec),
    .btn_min   (btn_min),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .alarm     (alarm),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mm = 0; m_ss = 0; m_st = 0; m_ac = 0;
    p_sec = 1; p_min = 1; p_start = 1; p_clear = 1;
  endtask

  task automatic model_step();
    bit e_sec, e_min, e_start, e_clear;
    int t;
    if (!reset_n) begin
      model_reset();
      return;
    end
    e_sec   = btn_sec   && !p_sec;
    e_min   = btn_min   && !p_min;
    e_start = btn_start && !p_start;
    e_clear = btn_clear && !p_clear;
    p_sec = btn_sec; p_min = btn_min; p_start = btn_start; p_clear = btn_clear;
    t = m_mm * 60 + m_ss;
    if (e_clear) begin
      m_mm = 0; m_ss = 0; m_st = 0; m_ac = 0;
    end else if (m_st == 0) begin
      if (e_start && t != 0) m_st = 1;
      else begin
        if (e_sec) m_ss = (m_ss + 1) % 60;
        if (e_min) m_mm = (m_mm + 1) % 100;
      end
    end else if (m_st == 1) begin
      if (tick_1hz) begin
        t = t - 1;
        m_mm = t / 60; m_ss = t % 60;
        if (t == 0) m_st = 3;
        else if (e_start) m_st = 2;
      end else if (e_start) m_st = 2;
    end else if (m_st == 2) begin
      if (e_start) m_st = 1;
    end else begin
      if (e_sec || e_min || e_start) begin
        m_st = 0; m_ac = 0;
      end else if (tick_1hz) begin
        m_ac++;
        if (m_ac == AT) begin m_st = 0; m_ac = 0; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".min_tens"}, 8'(min_tens), 8'(m_mm / 10));
    chk({tag, ".min_ones"}, 8'(min_ones), 8'(m_mm % 10));
    chk({tag, ".sec_tens"}, 8'(sec_tens), 8'(m_ss / 10));
    chk({tag, ".sec_ones"}, 8'(sec_ones), 8'(m_ss % 10));
    chk({tag, ".state"},    8'(state),    8'(m_st));
    chk({tag, ".running"},  8'(running),  8'(m_st == 1));
    chk({tag, ".alarm"},    8'(alarm),    8'(m_st == 3));
  endtask

  task automatic chk_disp(input string tag, input int mm, input int ss, input int st);
    chk({tag, ".mt"}, 8'(min_tens), 8'(mm / 10));
    chk({tag, ".mo"}, 8'(min_ones), 8'(mm % 10));
    chk({tag, ".st"}, 8'(sec_tens), 8'(ss / 10));
    chk({tag, ".so"}, 8'(sec_ones), 8'(ss % 10));
    chk({tag, ".state"}, 8'(state), 8'(st));
    chk({tag, ".running"}, 8'(running), 8'(st == 1));
    chk({tag, ".alarm"}, 8'(alarm), 8'(st == 3));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // 0=sec 1=min 2=start 3=clear
  task automatic press(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      case (b)
        0: btn_sec = 1'b1;
        1: btn_min = 1'b1;
        2: btn_start = 1'b1;
        default: btn_clear = 1'b1;
      endcase
      step("press_hi");
      btn_sec = 1'b0; btn_min = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
      step("press_lo");
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      step("tick");
      tick_1hz = 1'b0;
      step("tick_gap");
    end
  endtask

  initial begin
    model_reset();
    // Reset with start held: no RUN after release.
    btn_start = 1'b1;
    #1;
    chk_disp("reset_async", 0, 0, 0);
    step("in_reset");
    step("in_reset");
    #2 reset_n = 1'b1;
    step("start_held");
    step("start_held");
    chk_disp("held_start", 0, 0, 0);
    btn_start = 1'b0;
    step("start_rel");

    press(1, 3);
    press(0, 62);
    chk_disp("set_0302", 3, 2, 0);

    // 01:00 countdown to alarm.
    press(3, 1);
    press(1, 1);
    press(2, 1);
    chk_disp("run_0100", 1, 0, 1);
    ticks(1);
    chk_disp("run_0059", 0, 59, 1);
    ticks(58);
    chk_disp("run_0001", 0, 1, 1);
    tick_1hz = 1'b1;
    step("last_tick");
    chk_disp("alarm_0000", 0, 0, 3);
    tick_1hz = 1'b0;
    step("alarm_gap");
    ticks(2);
    chk_disp("alarm_2t", 0, 0, 3);
    ticks(1);
    chk_disp("alarm_auto_ret", 0, 0, 0);

    // Tick + start together at 00:10.
    press(0, 10);
    press(2, 1);
    tick_1hz = 1'b1; btn_start = 1'b1;
    step("tick_start");
    tick_1hz = 1'b0; btn_start = 1'b0;
    chk_disp("pause_0009", 0, 9, 2);
    ticks(4);
    chk_disp("pause_hold", 0, 9, 2);
    press(2, 1);
    chk_disp("resume", 0, 9, 1);
    ticks(9);
    chk_disp("alarm2", 0, 0, 3);
    press(0, 1);
    chk_disp("alarm_sec_exit", 0, 0, 0);

    // Clear in RUN at 12:34.
    press(1, 12);
    press(0, 34);
    press(2, 1);
    chk_disp("run_1234", 12, 34, 1);
    press(3, 1);
    chk_disp("clear_run", 0, 0, 0);

    // Asynchronous reset mid-countdown at 05:00.
    press(1, 5);
    press(2, 1);
    ticks(1);
    chk_disp("run_0459", 4, 59, 1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk_disp("async_reset", 0, 0, 0);
    #2 reset_n = 1'b1;
    step("post_reset");

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      btn_sec   = ($urandom_range(0, 11) == 0);
      btn_min   = ($urandom_range(0, 15) == 0);
      btn_start = ($urandom_range(0, 11) == 0);
      btn_clear = ($urandom_range(0, 199) == 0);
      tick_1hz  = ($urandom_range(0, 1) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
